// File: rtl/binary_maxpool_stage_pkg.sv
// Shared types and constants for the binary 2x2 max-pool stage.
package binary_maxpool_stage_pkg;

  localparam int DIM_W = 5;
  localparam logic [15:0] END_WORD_DEFAULT = 16'h00FF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_CAP,
    S_HDR_WR,
    S_ROW_A,
    S_ROW_B,
    S_ROW_C,
    S_ROW_WR,
    S_END_WR
  } state_t;

  // Pooled dimension: odd inputs drop their last row/column.
  function automatic logic [DIM_W-1:0] pool_dim(input logic [DIM_W-1:0] dim);
    return dim >> 1;
  endfunction

endpackage

// File: rtl/binary_maxpool_stage_pool_row.sv
// Combinational 2x2 OR-pool of one row pair; output bits at or above p are cleared.
module binary_maxpool_stage_pool_row
  import binary_maxpool_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DIM_W-1:0]  p,
  output logic [DATA_W-1:0] pooled
);

  localparam int N_OUT = DATA_W / 2;

  always_comb begin
    pooled = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (DIM_W'(j) < p) begin
        pooled[j] = a[2*j] | a[2*j+1] | b[2*j] | b[2*j+1];
      end
    end
  end

endmodule

// File: rtl/binary_maxpool_stage.sv
// Streams binary feature maps out of the conv SRAM, 2x2 max-pools each image and
// writes header plus pooled rows to the pool SRAM, finishing with the terminator word.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | waiting for dut_run
//   S_HDR_RD  | header address on the read port
//   S_HDR_CAP | header data valid: terminator check, load D/P, next base
//   S_HDR_WR  | emit pooled header {0,P}
//   S_ROW_A   | address of row 2k on the read port
//   S_ROW_B   | address of row 2k+1 on the read port, capture row 2k
//   S_ROW_C   | capture row 2k+1
//   S_ROW_WR  | emit pooled row, count down remaining rows
//   S_END_WR  | emit terminator, drop busy
module binary_maxpool_stage
  import binary_maxpool_stage_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] END_WORD = DATA_W'(END_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] pool_sram_read_address,
  input  logic [DATA_W-1:0] sram_pool_read_data,
  output logic [ADDR_W-1:0] pool_sram_write_address,
  output logic [DATA_W-1:0] pool_sram_write_data,
  output logic              pool_sram_write_enable
);

  state_t state, state_next;

  logic [ADDR_W-1:0] img_base;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DIM_W-1:0]  p_reg;
  logic [DIM_W-1:0]  rows_left;
  logic [DATA_W-1:0] row_a;
  logic [DATA_W-1:0] row_b;
  logic [DATA_W-1:0] pooled;

  logic              hdr_is_end;
  logic [DIM_W-1:0]  hdr_dim;
  logic [DIM_W-1:0]  hdr_p;

  assign hdr_is_end = (sram_pool_read_data == END_WORD);
  assign hdr_dim    = sram_pool_read_data[DIM_W-1:0];
  assign hdr_p      = pool_dim(hdr_dim);

  binary_maxpool_stage_pool_row #(
    .DATA_W (DATA_W)
  ) u_pool_row (
    .a      (row_a),
    .b      (row_b),
    .p      (p_reg),
    .pooled (pooled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next             = state;
    pool_sram_read_address = '0;
    case (state)
      S_IDLE: begin
        if (dut_run) state_next = S_HDR_RD;
      end
      S_HDR_RD: begin
        pool_sram_read_address = img_base;
        state_next             = S_HDR_CAP;
      end
      S_HDR_CAP: begin
        state_next = hdr_is_end ? S_END_WR : S_HDR_WR;
      end
      S_HDR_WR: begin
        state_next = (p_reg == '0) ? S_HDR_RD : S_ROW_A;
      end
      S_ROW_A: begin
        pool_sram_read_address = rd_ptr;
        state_next             = S_ROW_B;
      end
      S_ROW_B: begin
        pool_sram_read_address = rd_ptr;
        state_next             = S_ROW_C;
      end
      S_ROW_C: begin
        state_next = S_ROW_WR;
      end
      S_ROW_WR: begin
        state_next = (rows_left == '0) ? S_HDR_RD : S_ROW_A;
      end
      S_END_WR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_base                <= '0;
      rd_ptr                  <= '0;
      wr_ptr                  <= '0;
      p_reg                   <= '0;
      rows_left               <= '0;
      row_a                   <= '0;
      row_b                   <= '0;
      dut_busy                <= 1'b0;
      pool_sram_write_address <= '0;
      pool_sram_write_data    <= '0;
      pool_sram_write_enable  <= 1'b0;
    end else begin
      pool_sram_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dut_run) begin
            img_base <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            dut_busy <= 1'b1;
          end
        end
        S_HDR_CAP: begin
          if (!hdr_is_end) begin
            p_reg     <= hdr_p;
            rows_left <= hdr_p - DIM_W'(1);
            rd_ptr    <= img_base + ADDR_W'(1);
            // Every image advances by D+1 words, even when odd rows are never read.
            img_base  <= img_base + ADDR_W'(hdr_dim) + ADDR_W'(1);
          end
        end
        S_HDR_WR: begin
          pool_sram_write_enable  <= 1'b1;
          pool_sram_write_address <= wr_ptr;
          pool_sram_write_data    <= DATA_W'(p_reg);
          wr_ptr                  <= wr_ptr + ADDR_W'(1);
        end
        S_ROW_A: begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        S_ROW_B: begin
          row_a  <= sram_pool_read_data;
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        S_ROW_C: begin
          row_b <= sram_pool_read_data;
        end
        S_ROW_WR: begin
          pool_sram_write_enable  <= 1'b1;
          pool_sram_write_address <= wr_ptr;
          pool_sram_write_data    <= pooled;
          wr_ptr                  <= wr_ptr + ADDR_W'(1);
          rows_left               <= rows_left - DIM_W'(1);
        end
        S_END_WR: begin
          pool_sram_write_enable  <= 1'b1;
          pool_sram_write_address <= wr_ptr;
          pool_sram_write_data    <= END_WORD;
          wr_ptr                  <= wr_ptr + ADDR_W'(1);
          dut_busy                <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_maxpool_stage.sv
// Bench for binary_maxpool_stage: SRAM models, directed stream cases and random
// streams compared against an image-level pooling reference.
module tb_binary_maxpool_stage;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int MEM    = 4096;
  localparam logic [15:0] END_W = 16'h00FF;

  logic              clk = 1'b0;
  logic              reset;
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] pool_sram_read_address;
  logic [DATA_W-1:0] sram_pool_read_data;
  logic [ADDR_W-1:0] pool_sram_write_address;
  logic [DATA_W-1:0] pool_sram_write_data;
  logic              pool_sram_write_enable;

  always #5 clk = ~clk;

  binary_maxpool_stage #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .END_WORD (END_W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .dut_run                 (dut_run),
    .dut_busy                (dut_busy),
    .pool_sram_read_address  (pool_sram_read_address),
    .sram_pool_read_data     (sram_pool_read_data),
    .pool_sram_write_address (pool_sram_write_address),
    .pool_sram_write_data    (pool_sram_write_data),
    .pool_sram_write_enable  (pool_sram_write_enable)
  );

  logic [15:0] conv_mem [MEM];

  always @(posedge clk) sram_pool_read_data <= conv_mem[pool_sram_read_address];

  logic [11:0] wr_addr_log [$];
  logic [15:0] wr_data_log [$];
  logic [11:0] rd_log [$];
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (pool_sram_write_enable === 1'b1) begin
      wr_addr_log.push_back(pool_sram_write_address);
      wr_data_log.push_back(pool_sram_write_data);
    end
    if (dut_busy === 1'b1) begin
      busy_cnt++;
      rd_log.push_back(pool_sram_read_address);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd_at(input int i);
    if (i < wr_data_log.size()) return 32'(wr_data_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wa_at(input int i);
    if (i < wr_addr_log.size()) return 32'(wr_addr_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Reference model: walk images from address 0 using the header rules.
  logic [11:0] exp_wa [$];
  logic [15:0] exp_wd [$];
  bit          exp_req  [MEM];
  bit          exp_forb [MEM];
  bit          seen     [MEM];
  int          exp_busy;

  task automatic build_model();
    int base, wp, n_img, d, p, ra, rb;
    logic [15:0] hdr, va, vb, word;
    base = 0; wp = 0; n_img = 0;
    exp_wa.delete(); exp_wd.delete(); exp_busy = 0;
    for (int i = 0; i < MEM; i++) begin exp_req[i] = 0; exp_forb[i] = 0; end
    while (n_img < 1000) begin
      hdr = conv_mem[base];
      exp_req[base] = 1;
      if (hdr == END_W) begin
        exp_wa.push_back(12'(wp)); exp_wd.push_back(END_W);
        exp_busy += 3;
        break;
      end
      d = int'(hdr) % 32;
      p = d / 2;
      exp_wa.push_back(12'(wp)); exp_wd.push_back(16'(p));
      wp = (wp + 1) % MEM;
      for (int i = 0; i < p; i++) begin
        ra = (base + 1 + 2*i) % MEM;
        rb = (base + 2 + 2*i) % MEM;
        exp_req[ra] = 1; exp_req[rb] = 1;
        va = conv_mem[ra]; vb = conv_mem[rb];
        word = '0;
        for (int j = 0; j < p; j++)
          if (va[2*j] || va[2*j+1] || vb[2*j] || vb[2*j+1]) word[j] = 1'b1;
        exp_wa.push_back(12'(wp)); exp_wd.push_back(word);
        wp = (wp + 1) % MEM;
      end
      for (int r = 2*p; r < d; r++) exp_forb[(base + 1 + r) % MEM] = 1;
      exp_busy += 3 + 4*p;
      base = (base + d + 1) % MEM;
      n_img++;
    end
  endtask

  task automatic run_stream(input int hold, output int wstart, output int rstart, output int bstart);
    int n, miss, forb;
    build_model();
    wstart = wr_addr_log.size();
    rstart = rd_log.size();
    bstart = busy_cnt;
    @(negedge clk); dut_run = 1'b1;
    repeat (hold) @(negedge clk);
    dut_run = 1'b0;
    n = 0;
    while (dut_busy && n < 20000) begin @(negedge clk); n++; end
    check_eq("busy_timeout", 32'(dut_busy), 0);
    repeat (2) @(negedge clk);
    check_eq("wr_count", 32'(wr_addr_log.size() - wstart), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size(); i++) begin
      check_eq($sformatf("wr_addr[%0d]", i), wa_at(wstart + i), 32'(exp_wa[i]));
      check_eq($sformatf("wr_data[%0d]", i), wd_at(wstart + i), 32'(exp_wd[i]));
    end
    check_eq("busy_cycles", 32'(busy_cnt - bstart), 32'(exp_busy));
    for (int i = 0; i < MEM; i++) seen[i] = 0;
    for (int i = rstart; i < rd_log.size(); i++) seen[rd_log[i]] = 1;
    miss = 0; forb = 0;
    for (int i = 0; i < MEM; i++) begin
      if (exp_req[i] && !seen[i]) miss++;
      if (exp_forb[i] && !exp_req[i] && seen[i]) forb++;
    end
    check_eq("rd_missing", 32'(miss), 0);
    check_eq("rd_forbidden", 32'(forb), 0);
    check_eq("busy_after", 32'(dut_busy), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM; i++) conv_mem[i] = 16'($urandom);
  endtask

  initial begin
    int w0, r0, b0, base, d, n_img, found;
    reset = 1'b1;
    dut_run = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(dut_busy), 0);
    check_eq("rst_we", 32'(pool_sram_write_enable), 0);
    check_eq("rst_wa", 32'(pool_sram_write_address), 0);
    check_eq("rst_wd", 32'(pool_sram_write_data), 0);
    check_eq("rst_ra", 32'(pool_sram_read_address), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8x8 alternating columns
    fill_random();
    conv_mem[0] = 16'd8;
    for (int r = 0; r < 8; r++) conv_mem[1 + r] = (r % 2 == 1) ? 16'h0055 : 16'h00AA;
    conv_mem[9] = END_W;
    run_stream(1, w0, r0, b0);
    check_eq("t1_hdr", wd_at(w0), 32'h4);
    for (int i = 1; i <= 4; i++) check_eq("t1_row", wd_at(w0 + i), 32'h000F);
    check_eq("t1_end_addr", wa_at(w0 + 5), 32'd5);
    check_eq("t1_end_data", wd_at(w0 + 5), 32'h00FF);

    // 14x14 checkerboard, then 10x10 zeros
    fill_random();
    conv_mem[0] = 16'd14;
    for (int r = 0; r < 14; r++) conv_mem[1 + r] = (r % 2 == 1) ? 16'h1555 : 16'h2AAA;
    conv_mem[15] = 16'd10;
    for (int r = 0; r < 10; r++) conv_mem[16 + r] = 16'h0000;
    conv_mem[26] = END_W;
    run_stream(1, w0, r0, b0);
    check_eq("t2_hdr0", wd_at(w0), 32'd7);
    check_eq("t2_row0", wd_at(w0 + 1), 32'h007F);
    check_eq("t2_hdr1", wd_at(w0 + 8), 32'd5);
    check_eq("t2_row1", wd_at(w0 + 9), 32'h0000);
    check_eq("t2_end_addr", wa_at(w0 + 14), 32'd14);

    // odd D=9: last row/column dropped, next header at base+10
    fill_random();
    conv_mem[0] = 16'd9;
    for (int r = 0; r < 9; r++) conv_mem[1 + r] = 16'h01FF;
    conv_mem[10] = END_W;
    run_stream(1, w0, r0, b0);
    check_eq("t4_hdr", wd_at(w0), 32'd4);
    check_eq("t4_row", wd_at(w0 + 2), 32'h000F);
    found = 0;
    for (int i = r0; i < rd_log.size(); i++) if (rd_log[i] == 12'd10) found = 1;
    check_eq("t4_hdr_at_10", 32'(found), 1);

    // empty stream
    fill_random();
    conv_mem[0] = END_W;
    run_stream(1, w0, r0, b0);
    check_eq("t5_busy", 32'(busy_cnt - b0), 32'd3);
    check_eq("t5_addr", wa_at(w0), 32'd0);
    check_eq("t5_data", wd_at(w0), 32'h00FF);

    // lone-pixel sweep over a 16x16 image
    fill_random();
    conv_mem[0]  = 16'd16;
    conv_mem[17] = END_W;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        for (int k = 1; k <= 16; k++) conv_mem[k] = 16'h0000;
        conv_mem[1 + r] = 16'(1 << c);
        run_stream(1, w0, r0, b0);
        check_eq($sformatf("t3_pix_%0d_%0d", r, c), wd_at(w0 + 1 + r/2), 32'(1 << (c/2)));
      end
    end

    // reset during ROW_B of the first image, then a clean rerun
    fill_random();
    conv_mem[0]  = 16'd16;
    conv_mem[17] = END_W;
    @(negedge clk); dut_run = 1'b1;
    @(negedge clk); dut_run = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    w0 = wr_addr_log.size();
    @(posedge clk); #1;
    check_eq("t6_we", 32'(pool_sram_write_enable), 0);
    check_eq("t6_busy", 32'(dut_busy), 0);
    check_eq("t6_wa", 32'(pool_sram_write_address), 0);
    check_eq("t6_wd", 32'(pool_sram_write_data), 0);
    check_eq("t6_ra", 32'(pool_sram_read_address), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_no_writes", 32'(wr_addr_log.size() - w0), 0);
    run_stream(1, w0, r0, b0);

    // read-address wrap: 241 16x16 images, next header lands at address 1
    fill_random();
    conv_mem[0] = 16'h0010;
    conv_mem[1] = END_W;
    for (int img = 1; img <= 240; img++) begin
      base = 17 * img;
      conv_mem[base] = (16'($urandom) & 16'hFFE0) | 16'd16;
      for (int r = 0; r < 16; r++)
        if (base + 1 + r < MEM) conv_mem[base + 1 + r] = 16'($urandom);
    end
    run_stream(3, w0, r0, b0);

    // random streams
    for (int t = 0; t < 20; t++) begin
      fill_random();
      base = 0;
      n_img = $urandom_range(1, 4);
      for (int i = 0; i < n_img; i++) begin
        d = $urandom_range(0, 16);
        conv_mem[base] = (16'($urandom) & 16'hFFE0) | 16'(d);
        base += d + 1;
      end
      conv_mem[base] = END_W;
      run_stream(3, w0, r0, b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
